// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression core with an on-the-fly message schedule.
// Optional macro SHA256_IV_EN adds a use_iv input that substitutes the standard IV for chain_in.
module sha256_round_engine #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int ROUNDS           = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic [255:0] chain_in,
`ifdef SHA256_IV_EN
    input  logic         use_iv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest_out,
    output logic         busy
);

    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [6:0] LAST_CNT = 7'(ROUNDS - R);

    generate
        if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds_per_cycle
            $error("sha256_round_engine: ROUNDS_PER_CYCLE must be 1, 2 or 4");
        end
        if ((ROUNDS % R) != 0 || ROUNDS > 64 || ROUNDS < R) begin : g_bad_rounds
            $error("sha256_round_engine: ROUNDS must be a multiple of ROUNDS_PER_CYCLE and at most 64");
        end
    endgenerate

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINAL,
        ST_DONE
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // Working state is packed {a,b,c,d,e,f,g,h} with a in the top word, like chain_in.
    function automatic logic [255:0] round_step(input logic [255:0] s, input logic [31:0] k,
                                                input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
        t2 = big_sigma0(a) + maj(a, b, c);
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    state_t        state;
    state_t        next_state;
    logic [6:0]    round_cnt;
    logic [255:0]  work;
    logic [255:0]  h_reg;
    logic [31:0]   sched [16];
    logic [31:0]   ext [16+R];
    logic [255:0]  stage [R+1];
    logic [255:0]  chain_sel;
    logic          accept;
    logic          last_run;

`ifdef SHA256_IV_EN
    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    assign chain_sel = use_iv ? SHA256_IV : chain_in;
`else
    assign chain_sel = chain_in;
`endif

    // State is IDLE throughout reset, so qualify ready with rst to keep it low while asserted.
    assign in_ready = (state == ST_IDLE) && rst;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_RUN) || (state == ST_FINAL);
    assign last_run = (round_cnt == LAST_CNT);

    // ext[k] holds W[t+k]; the R words past the window are derived in series.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext[i] = sched[i];
        end
        for (int j = 0; j < R; j++) begin
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        end
    end

    always_comb begin
        stage[0] = work;
        for (int i = 0; i < R; i++) begin
            stage[i+1] = round_step(stage[i], K_ROM[round_cnt[5:0] + 6'(i)], ext[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (accept) next_state = ST_RUN;
            ST_RUN:   if (last_run) next_state = ST_FINAL;
            ST_FINAL: next_state = ST_DONE;
            ST_DONE:  if (out_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            round_cnt  <= '0;
            work       <= '0;
            h_reg      <= '0;
            digest_out <= '0;
            out_valid  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                sched[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        round_cnt <= '0;
                        work      <= chain_sel;
                        h_reg     <= chain_sel;
                        for (int i = 0; i < 16; i++) begin
                            sched[i] <= block_in[511-32*i -: 32];
                        end
                    end
                end
                ST_RUN: begin
                    round_cnt <= round_cnt + 7'(R);
                    work      <= stage[R];
                    for (int i = 0; i < 16; i++) begin
                        sched[i] <= ext[i+R];
                    end
                end
                ST_FINAL: begin
                    digest_out <= add_words(h_reg, work);
                    out_valid  <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Self-checking bench for sha256_round_engine with R=1, 2 and 4 instances.
// Exercises use_iv when compiled with SHA256_IV_EN.
module tb_sha256_round_engine;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] DIG_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] BLK_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
        32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] BLK_TWO2 = {480'h0, 32'h000001c0};

    typedef struct {
        logic [511:0] blk;
        logic [255:0] chn;
        bit           iv;
        int           d;
        logic [255:0] exp;
        int           lat;
    } vec_t;

    typedef struct {
        logic [255:0] digest;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [511:0] block_in = '0;
    logic [255:0] chain_in = '0;
`ifdef SHA256_IV_EN
    logic         use_iv = 1'b0;
`endif
    logic         in_valid_v  [3];
    logic         out_ready_v [3];
    logic         in_ready_v  [3];
    logic         out_valid_v [3];
    logic         busy_v      [3];
    logic [255:0] digest_v    [3];

    int   cyc = 0;
    int   acc_cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb [$];
    vec_t vecs [$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sha256_round_engine #(.ROUNDS_PER_CYCLE(1), .ROUNDS(64)) dut_r1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .block_in(block_in), .chain_in(chain_in),
`ifdef SHA256_IV_EN
        .use_iv(use_iv),
`endif
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .digest_out(digest_v[0]), .busy(busy_v[0])
    );

    sha256_round_engine #(.ROUNDS_PER_CYCLE(2), .ROUNDS(64)) dut_r2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .block_in(block_in), .chain_in(chain_in),
`ifdef SHA256_IV_EN
        .use_iv(use_iv),
`endif
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .digest_out(digest_v[1]), .busy(busy_v[1])
    );

    sha256_round_engine #(.ROUNDS_PER_CYCLE(4), .ROUNDS(64)) dut_r4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .block_in(block_in), .chain_in(chain_in),
`ifdef SHA256_IV_EN
        .use_iv(use_iv),
`endif
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .digest_out(digest_v[2]), .busy(busy_v[2])
    );

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight FIPS 180-4 compression with a full 64-word schedule.
    function automatic logic [255:0] sha_model(input logic [511:0] blk, input logic [255:0] chn);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) v[i] = chn[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        res = '0;
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = chn[255-32*i -: 32] + v[i];
        return res;
    endfunction

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Drives one block into instance d; returns at the negedge just after the accept edge.
    task automatic apply_stimulus(input int d, input logic [511:0] blk, input logic [255:0] chn, input bit iv);
        @(negedge clk);
        check_output("in_ready_idle", in_ready_v[d], 1);
        block_in = blk;
        chain_in = chn;
`ifdef SHA256_IV_EN
        use_iv = iv;
`else
        if (iv) $display("[TB] use_iv requested but not built in");
`endif
        in_valid_v[d] = 1'b1;
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        acc_cyc = cyc;
        check_output("busy_after_accept", busy_v[d], 1);
        block_in = {16{$urandom()}};
        chain_in = {8{$urandom()}};
    endtask

    task automatic wait_and_score(input int d, input string name);
        int   n;
        exp_t e;
        n = 0;
        while (out_valid_v[d] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        if (out_valid_v[d] !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: out_valid not seen, expected within 200 cycles", name);
        end else begin
            check_output({name, "_digest"}, digest_v[d], e.digest);
            check_output({name, "_latency"}, 256'(cyc - acc_cyc), 256'(e.lat));
        end
    endtask

    task automatic release_digest(input int d);
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        out_ready_v[d] = 1'b0;
        check_output("out_valid_cleared", out_valid_v[d], 0);
        check_output("in_ready_returned", in_ready_v[d], 1);
    endtask

    task automatic run_one(input vec_t v, input string name);
        apply_stimulus(v.d, v.blk, v.chn, v.iv);
        sb.push_back('{digest: v.exp, lat: v.lat});
        wait_and_score(v.d, name);
        release_digest(v.d);
    endtask

    initial begin
        logic [255:0] mid;
        vec_t         v;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b0;
        end

        mid = sha_model(BLK_TWO1, IV);
        vecs.push_back('{blk: BLK_ABC,   chn: IV,  iv: 1'b0, d: 0, exp: DIG_ABC,   lat: 65});
        vecs.push_back('{blk: BLK_EMPTY, chn: IV,  iv: 1'b0, d: 1, exp: DIG_EMPTY, lat: 33});
        vecs.push_back('{blk: BLK_EMPTY, chn: IV,  iv: 1'b0, d: 2, exp: DIG_EMPTY, lat: 17});
        vecs.push_back('{blk: BLK_ABC,   chn: IV,  iv: 1'b0, d: 2, exp: DIG_ABC,   lat: 17});
        vecs.push_back('{blk: BLK_TWO1,  chn: IV,  iv: 1'b0, d: 0, exp: mid,       lat: 65});
        vecs.push_back('{blk: BLK_TWO2,  chn: mid, iv: 1'b0, d: 1, exp: DIG_TWO,   lat: 33});
`ifdef SHA256_IV_EN
        vecs.push_back('{blk: BLK_ABC,   chn: '0,  iv: 1'b1, d: 0, exp: DIG_ABC,   lat: 65});
        vecs.push_back('{blk: BLK_ABC,   chn: '0,  iv: 1'b0, d: 2, exp: sha_model(BLK_ABC, '0), lat: 17});
`endif

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("reset_in_ready%0d", i), in_ready_v[i], 0);
            check_output($sformatf("reset_busy%0d", i), busy_v[i], 0);
            check_output($sformatf("reset_out_valid%0d", i), out_valid_v[i], 0);
            check_output($sformatf("reset_digest%0d", i), digest_v[i], 0);
        end
        rst = 1'b1;

        foreach (vecs[i]) begin
            run_one(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: early out_ready is ignored, then a 10-cycle stall in DONE.
        apply_stimulus(0, BLK_ABC, IV, 1'b0);
        out_ready_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_output("early_ready_busy", busy_v[0], 1);
        check_output("early_ready_valid", out_valid_v[0], 0);
        out_ready_v[0] = 1'b0;
        sb.push_back('{digest: DIG_ABC, lat: 65});
        wait_and_score(0, "stall");
        for (int k = 0; k < 10; k++) begin
            check_output("stall_digest", digest_v[0], DIG_ABC);
            check_output("stall_in_ready", in_ready_v[0], 0);
            check_output("stall_valid", out_valid_v[0], 1);
            in_valid_v[0] = k[0];
            block_in = {16{$urandom()}};
            @(negedge clk);
        end
        in_valid_v[0] = 1'b0;
        release_digest(0);
        @(negedge clk);
        check_output("no_stray_accept", busy_v[0], 0);

        // Reset dropped between clock edges partway through the rounds.
        apply_stimulus(0, BLK_ABC, IV, 1'b0);
        repeat (19) @(negedge clk);
        check_output("pre_reset_busy", busy_v[0], 1);
        #2 rst = 1'b0;
        #1;
        check_output("abort_busy", busy_v[0], 0);
        check_output("abort_valid", out_valid_v[0], 0);
        check_output("abort_digest", digest_v[0], 0);
        check_output("abort_in_ready", in_ready_v[0], 0);
        @(negedge clk);
        rst = 1'b1;
        v = vecs[0];
        run_one(v, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
